// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter: drains VC0/VC1 FIFOs into one downstream FIFO.
// Weighted arbitration (VC0 favoured), 1-cycle registered output.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   enable              arbitration enable; low stops all pops
//   vcN_empty/vcN_data  VC FIFO status and same-cycle read data
//   vcN_rd              combinational pop strobes
//   dst_almost_full     downstream backpressure, sampled combinationally
//   dst_wr/dst_data     registered downstream write
//   pop_cnt0/pop_cnt1   wrapping per-VC pop counters
//   state               FSM state (IDLE/ACTIVE/HOLD), debug only
module vc_pop_arbiter #(
  parameter int BW     = 6,
  parameter int WEIGHT = 3,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             vc0_empty,
  input  logic [BW-1:0]    vc0_data,
  output logic             vc0_rd,
  input  logic             vc1_empty,
  input  logic [BW-1:0]    vc1_data,
  output logic             vc1_rd,
  input  logic             dst_almost_full,
  output logic             dst_wr,
  output logic [BW-1:0]    dst_data,
  output logic [CNT_W-1:0] pop_cnt0,
  output logic [CNT_W-1:0] pop_cnt1,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam logic [3:0] WMAX = 4'(WEIGHT);

  state_e     st_q, st_d;
  logic [3:0] credit_q, credit_d;
  logic       go, nz0, nz1;
  logic       gnt0, gnt1;
  logic       pop0, pop1;

  assign nz0 = !vc0_empty;
  assign nz1 = !vc1_empty;
  assign go  = enable && !dst_almost_full && !reset;

  // credit counts VC0 grants made while VC1 was waiting
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      (nz0 && nz1): begin
        if (credit_q == WMAX) gnt1 = 1'b1;
        else                  gnt0 = 1'b1;
      end
      (nz0 && !nz1): gnt0 = 1'b1;
      (!nz0 && nz1): gnt1 = 1'b1;
      default: ;
    endcase
  end

  assign pop0   = go && gnt0;
  assign pop1   = go && gnt1;
  assign vc0_rd = pop0;
  assign vc1_rd = pop1;

  always_comb begin
    credit_d = credit_q;
    if (pop1) begin
      credit_d = '0;
    end else if (pop0 && nz1) begin
      if (credit_q == WMAX) credit_d = WMAX;
      else                  credit_d = credit_q + 4'd1;
    end else if (pop0) begin
      credit_d = '0;
    end
  end

  always_comb begin
    st_d = IDLE;
    if (!enable)
      st_d = IDLE;
    else if (dst_almost_full && (nz0 || nz1))
      st_d = HOLD;
    else if (pop0 || pop1)
      st_d = ACTIVE;
    else
      st_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q     <= IDLE;
      credit_q <= '0;
      dst_wr   <= 1'b0;
      dst_data <= '0;
      pop_cnt0 <= '0;
      pop_cnt1 <= '0;
    end else begin
      st_q     <= st_d;
      credit_q <= credit_d;
      dst_wr   <= pop0 | pop1;
      if (pop0)
        dst_data <= vc0_data;
      else if (pop1)
        dst_data <= vc1_data;
      if (pop0) pop_cnt0 <= pop_cnt0 + 1'b1;
      if (pop1) pop_cnt1 <= pop_cnt1 + 1'b1;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// tb_vc_pop_arbiter: scoreboard bench for vc_pop_arbiter.
// Reference model tracks FIFOs, VC0 streak, counts and state.
module tb_vc_pop_arbiter;

  localparam int W = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       vc0_empty, vc1_empty;
  logic [5:0] vc0_data, vc1_data;
  logic       vc0_rd, vc1_rd;
  logic       dst_almost_full;
  logic       dst_wr;
  logic [5:0] dst_data;
  logic [7:0] pop_cnt0, pop_cnt1;
  logic [1:0] state;

  vc_pop_arbiter #(.BW(6), .WEIGHT(W), .CNT_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .vc0_empty(vc0_empty),
    .vc0_data(vc0_data),
    .vc0_rd(vc0_rd),
    .vc1_empty(vc1_empty),
    .vc1_data(vc1_data),
    .vc1_rd(vc1_rd),
    .dst_almost_full(dst_almost_full),
    .dst_wr(dst_wr),
    .dst_data(dst_data),
    .pop_cnt0(pop_cnt0),
    .pop_cnt1(pop_cnt1),
    .state(state)
  );

  always #5 clk = ~clk;

  bit [5:0] q0[$];
  bit [5:0] q1[$];
  bit [5:0] expq[$];
  int       gseq[$];
  bit       logg = 1'b0;
  int       errors = 0;
  int       checks = 0;
  int       streak = 0;
  int       cnt0 = 0;
  int       cnt1 = 0;
  int       est = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    expq.delete();
    streak = 0;
    cnt0   = 0;
    cnt1   = 0;
    est    = 0;
  endtask

  // one clock cycle: drive, check strobes, update model, check status
  task automatic step(input bit en, input bit af);
    bit n0, n1, go, g0, g1, e0, e1;
    @(negedge clk);
    enable          = en;
    dst_almost_full = af;
    n0 = (q0.size() != 0);
    n1 = (q1.size() != 0);
    vc0_empty = !n0;
    vc1_empty = !n1;
    vc0_data  = n0 ? q0[0] : 6'($urandom);
    vc1_data  = n1 ? q1[0] : 6'($urandom);
    #1;
    go = en && !af;
    g0 = n0 && (!n1 || streak < W);
    g1 = n1 && !g0;
    e0 = go && g0;
    e1 = go && g1;
    chk("strobes", {30'd0, vc0_rd, vc1_rd}, {30'd0, e0, e1});
    if (logg && (vc0_rd || vc1_rd))
      gseq.push_back(vc1_rd ? 1 : 0);
    @(posedge clk);
    if (e0) begin
      expq.push_back(q0.pop_front());
      cnt0++;
      if (!n1)         streak = 0;
      else if (streak < W) streak = streak + 1;
    end
    if (e1) begin
      expq.push_back(q1.pop_front());
      cnt1++;
      streak = 0;
    end
    if (!en)                   est = 0;
    else if (af && (n0 || n1)) est = 2;
    else if (e0 || e1)         est = 1;
    else                       est = 0;
    #1;
    chk("status",
        {14'd0, state, pop_cnt0, pop_cnt1},
        {14'd0, est[1:0], cnt0[7:0], cnt1[7:0]});
  endtask

  // monitor: every downstream write must match the scoreboard head
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (dst_wr === 1'b1) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_wr: got data %0h expected no write",
                   dst_data);
        end else begin
          chk("dst_data", {26'd0, dst_data}, {26'd0, expq.pop_front()});
        end
      end
    end
  end

  int pat[8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    dst_almost_full = 1'b0;
    vc0_empty = 1'b0;
    vc1_empty = 1'b0;
    vc0_data = 6'h15;
    vc1_data = 6'h2a;
    #2;
    chk("rst_strobes", {30'd0, vc0_rd, vc1_rd}, 32'd0);
    chk("rst_regs",
        {7'd0, state, dst_wr, dst_data, pop_cnt0, pop_cnt1}, 32'd0);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    vc0_empty = 1'b1;
    vc1_empty = 1'b1;
    reset = 1'b0;
    model_reset();

    // two VC0 words, VC1 idle
    q0.push_back(6'h11);
    q0.push_back(6'h12);
    repeat (4) step(1'b1, 1'b0);
    chk("t1_cnt0", {24'd0, pop_cnt0}, 32'd2);

    // both VCs loaded: weighted grant pattern
    for (int i = 0; i < 8; i++) begin
      q0.push_back(6'(i));
      q1.push_back(6'(6'h20 + i));
    end
    gseq.delete();
    logg = 1'b1;
    repeat (8) step(1'b1, 1'b0);
    logg = 1'b0;
    chk("grant_len", gseq.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < gseq.size())
        chk("grant_seq", gseq[i], pat[i]);
    repeat (12) step(1'b1, 1'b0);

    // backpressure mid-burst
    for (int i = 0; i < 10; i++) begin
      q0.push_back(6'($urandom));
      q1.push_back(6'($urandom));
    end
    repeat (3) step(1'b1, 1'b0);
    repeat (4) step(1'b1, 1'b1);
    chk("hold_state", {30'd0, state}, 32'd2);
    repeat (20) step(1'b1, 1'b0);

    // VC1 arrives late while VC0 streams
    for (int i = 0; i < 10; i++) q0.push_back(6'(6'h30 + i));
    repeat (5) step(1'b1, 1'b0);
    q1.push_back(6'h3f);
    gseq.delete();
    logg = 1'b1;
    repeat (4) step(1'b1, 1'b0);
    logg = 1'b0;
    chk("late_vc1", gseq.size() == 4 ? gseq[3] : -1, 32'd1);
    repeat (4) step(1'b1, 1'b0);

    // async reset while a word is on the downstream port
    for (int i = 0; i < 3; i++) q0.push_back(6'(6'h08 + i));
    step(1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async",
        {13'd0, dst_wr, state, pop_cnt0, pop_cnt1}, 32'd0);
    model_reset();
    @(negedge clk);
    enable = 1'b1;
    vc0_empty = 1'b0;
    vc0_data = q0[0];
    #1;
    chk("rst_hold_strobe", {30'd0, vc0_rd, vc1_rd}, 32'd0);
    enable = 1'b0;
    reset = 1'b0;
    repeat (4) step(1'b1, 1'b0);

    // empty FIFOs with enable toggling
    for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 1'b0);

    // VC1 counter wrap
    for (int i = 0; i < 257; i++) q1.push_back(6'($urandom));
    repeat (258) step(1'b1, 1'b0);
    chk("wrap_cnt1", {24'd0, pop_cnt1}, 32'd1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) q0.push_back(6'($urandom));
      if ($urandom_range(0, 2) == 0) q1.push_back(6'($urandom));
      step($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0);
    end
    while (q0.size() + q1.size() > 0) step(1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b0);
    #2;
    chk("sb_empty", expq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
